fft_stage_sequencer: RTL and testbench

// - Upstream control stage of the radix-2 FFT datapath: walks all LOG2N stages of an in-place 1024-pt FFT

---
 rtl/fft_stage_sequencer_if.sv | 37 +++
 rtl/fft_stage_sequencer.sv | 142 ++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_sequencer_if.sv
// Control bundle between the FFT stage sequencer, the sample memory read port and the butterfly datapath.
// The master modport is the sequencer side; the slave modport is the memory/datapath side.
interface fft_stage_sequencer_if #(
  parameter int LOG2N = 10
);
  logic                 i_start;
  logic                 i_stall;
  logic                 o_rd_en;
  logic [LOG2N-3:0]     o_rd_addr1;
  logic [LOG2N-3:0]     o_rd_addr2;
  logic                 o_valid;
  logic [LOG2N-3:0]     o_addr1;
  logic [LOG2N-3:0]     o_addr2;
  logic [LOG2N-1:0]     o_stride;
  logic [LOG2N-2:0]     o_twiddle_offset1;
  logic [LOG2N-2:0]     o_twiddle_offset2;
  logic [LOG2N-2:0]     o_twiddle_offset3;
  logic [LOG2N-2:0]     o_twiddle_offset4;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    input  i_start, i_stall,
    output o_rd_en, o_rd_addr1, o_rd_addr2,
    output o_valid, o_addr1, o_addr2, o_stride,
    output o_twiddle_offset1, o_twiddle_offset2, o_twiddle_offset3, o_twiddle_offset4,
    output o_busy, o_done
  );

  modport slave (
    output i_start, i_stall,
    input  o_rd_en, o_rd_addr1, o_rd_addr2,
    input  o_valid, o_addr1, o_addr2, o_stride,
    input  o_twiddle_offset1, o_twiddle_offset2, o_twiddle_offset3, o_twiddle_offset4,
    input  o_busy, o_done
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Walks all radix-2 stages of an in-place FFT: one row-pair read per cycle, metadata delayed MEM_RD_LAT to meet read data.
// i_stall holds issue (k/stage/state frozen) while the metadata pipe keeps advancing with bubbles; DRAIN_CYCLES gap between stages.
module fft_stage_sequencer #(
  parameter int LOG2N        = 10,
  parameter int MEM_RD_LAT   = 1,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_stage_sequencer_if.master bus
);
  localparam int RW = LOG2N - 2;
  localparam int KW = LOG2N - 3;
  localparam int TW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic                 vld;
    logic [RW-1:0]        addr1;
    logic [RW-1:0]        addr2;
    logic [LOG2N-1:0]     stride;
    logic [3:0][TW-1:0]   tw;
  } meta_t;

  state_t           state, state_nxt;
  logic [SW-1:0]    stage;
  logic [KW-1:0]    k;
  logic [CW-1:0]    drain_cnt;
  logic             rd_en;
  logic             last_stage;
  logic             drain_end;
  logic [SW-1:0]    b;
  logic [SW-1:0]    shamt;
  logic [RW-1:0]    lo_mask;
  logic [RW-1:0]    row1, row2;
  logic [LOG2N-1:0] stride;
  logic [LOG2N-1:0] p [4];
  meta_t            meta_in;
  meta_t            pipe [MEM_RD_LAT];
  meta_t            pipe_out;

  assign last_stage = (stage == SW'(LOG2N - 1));
  assign drain_end  = (drain_cnt == CW'(DRAIN_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.i_start) state_nxt = ISSUE;
      ISSUE: if (!bus.i_stall && (k == '1)) state_nxt = DRAIN;
      DRAIN: if (drain_end) state_nxt = last_stage ? DONE : ISSUE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en          = (state == ISSUE) && !bus.i_stall;
    bus.o_rd_en    = rd_en;
    bus.o_rd_addr1 = (state == ISSUE) ? row1 : '0;
    bus.o_rd_addr2 = (state == ISSUE) ? row2 : '0;
    bus.o_busy     = (state != IDLE);
    bus.o_done     = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage     <= '0;
      k         <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == IDLE && bus.i_start) begin
        stage     <= '0;
        k         <= '0;
        drain_cnt <= '0;
      end
      if (rd_en) k <= k + KW'(1);
      if (state == DRAIN) begin
        if (drain_end) begin
          drain_cnt <= '0;
          if (!last_stage) stage <= stage + SW'(1);
        end else begin
          drain_cnt <= drain_cnt + CW'(1);
        end
      end
      if (state == DONE) stage <= '0;
    end
  end

  // Rows of a pair differ only in bit b: open a zero at b in k, the partner sets it.
  always_comb begin
    b       = (stage < SW'(2)) ? '0 : stage - SW'(2);
    lo_mask = (RW'(1) << b) - RW'(1);
    row1    = ((RW'(k) & ~lo_mask) << 1) | (RW'(k) & lo_mask);
    row2    = row1 | (RW'(1) << b);
    stride  = LOG2N'(1) << stage;
    shamt   = SW'(LOG2N - 1) - stage;
    for (int j = 0; j < 4; j++) begin
      if (stage >= SW'(2))
        p[j] = {row1, 2'(j)};
      else if (stage == SW'(1))
        p[j] = {(j < 2) ? row1 : row2, 1'b0, 1'(j % 2)};
      else
        p[j] = {(j < 2) ? row1 : row2, 1'(j % 2), 1'b0};
    end
    meta_in = '0;
    if (rd_en) begin
      meta_in.vld    = 1'b1;
      meta_in.addr1  = row1;
      meta_in.addr2  = row2;
      meta_in.stride = stride;
      for (int j = 0; j < 4; j++)
        meta_in.tw[j] = TW'((p[j] & (stride - LOG2N'(1))) << shamt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= meta_in;
      for (int i = 1; i < MEM_RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign pipe_out              = pipe[MEM_RD_LAT-1];
  assign bus.o_valid           = pipe_out.vld;
  assign bus.o_addr1           = pipe_out.addr1;
  assign bus.o_addr2           = pipe_out.addr2;
  assign bus.o_stride          = pipe_out.stride;
  assign bus.o_twiddle_offset1 = pipe_out.tw[0];
  assign bus.o_twiddle_offset2 = pipe_out.tw[1];
  assign bus.o_twiddle_offset3 = pipe_out.tw[2];
  assign bus.o_twiddle_offset4 = pipe_out.tw[3];
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: the driver pushes an expected bundle per accepted read,
// a monitor pops and compares whenever o_valid is seen.
module tb_fft_stage_sequencer;
  localparam int LOG2N = 10;
  localparam int DRAIN = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.LOG2N(LOG2N)) bus();

  fft_stage_sequencer #(
    .LOG2N(LOG2N), .MEM_RD_LAT(1), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    int s; int k; int a1; int a2; int stride; int cyc;
    logic [3:0][31:0] tw;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   vcount [LOG2N];

  // Hand-computed reference points (stage, k, addr1, addr2, stride, twiddles).
  int ds  [6] = '{0, 1, 5, 9, 2, 3};
  int dk  [6] = '{0, 3, 9, 127, 40, 5};
  int da1 [6] = '{0, 6, 17, 127, 80, 9};
  int da2 [6] = '{1, 7, 25, 255, 81, 11};
  int dst [6] = '{1, 2, 32, 512, 4, 8};
  int dtw [6][4] = '{'{0, 0, 0, 0}, '{0, 256, 0, 256}, '{64, 80, 96, 112},
                     '{508, 509, 510, 511}, '{0, 128, 256, 384}, '{256, 320, 384, 448}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
  endtask

  function automatic exp_t model(input int s, input int k);
    exp_t e;
    int b, p;
    e = '0;
    e.s = s;
    e.k = k;
    b = (s < 2) ? 0 : s - 2;
    for (int i = 0; i < 8; i++) begin
      if (i < b)      e.a1 |= ((k >> i) & 1) << i;
      else if (i > b) e.a1 |= ((k >> (i - 1)) & 1) << i;
    end
    e.a2 = e.a1 + (1 << b);
    e.stride = 1 << s;
    for (int j = 0; j < 4; j++) begin
      if (s >= 2)      p = 4 * e.a1 + j;
      else if (s == 1) p = (j < 2) ? 4 * e.a1 + j : 4 * e.a2 + (j - 2);
      else             p = (j < 2) ? 4 * e.a1 + 2 * j : 4 * e.a2 + 2 * (j - 2);
      e.tw[j] = 32'((p % e.stride) * (512 / e.stride));
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (rst_n && bus.o_valid) begin
      if (q.size() == 0) begin
        chk("valid_without_issue", 32'(bus.o_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("valid_latency", 32'(cyc), 32'(e.cyc + 1));
        chk("addr1", 32'(bus.o_addr1), 32'(e.a1));
        chk("addr2", 32'(bus.o_addr2), 32'(e.a2));
        chk("stride", 32'(bus.o_stride), 32'(e.stride));
        chk("tw1", 32'(bus.o_twiddle_offset1), e.tw[0]);
        chk("tw2", 32'(bus.o_twiddle_offset2), e.tw[1]);
        chk("tw3", 32'(bus.o_twiddle_offset3), e.tw[2]);
        chk("tw4", 32'(bus.o_twiddle_offset4), e.tw[3]);
        vcount[e.s]++;
        for (int d = 0; d < 6; d++) begin
          if (e.s == ds[d] && e.k == dk[d]) begin
            chk("vec_addr1", 32'(bus.o_addr1), 32'(da1[d]));
            chk("vec_addr2", 32'(bus.o_addr2), 32'(da2[d]));
            chk("vec_stride", 32'(bus.o_stride), 32'(dst[d]));
            chk("vec_tw1", 32'(bus.o_twiddle_offset1), 32'(dtw[d][0]));
            chk("vec_tw2", 32'(bus.o_twiddle_offset2), 32'(dtw[d][1]));
            chk("vec_tw3", 32'(bus.o_twiddle_offset3), 32'(dtw[d][2]));
            chk("vec_tw4", 32'(bus.o_twiddle_offset4), 32'(dtw[d][3]));
          end
        end
      end
    end else if (rst_n) begin
      chk("bubble_zero", {bus.o_addr1, bus.o_addr2, bus.o_twiddle_offset4}, 32'd0);
    end
  end

  // Runs an FFT from IDLE; returns early at the negedge where (stop_s, stop_k) would issue.
  task automatic run_fft(input int stop_s, input int stop_k);
    exp_t e;
    int   k;
    int   stall_left;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_stall = 1'b0;
    #1;
    chk("idle_busy", 32'(bus.o_busy), 32'd0);
    chk("idle_rd_en", 32'(bus.o_rd_en), 32'd0);
    for (int s = 0; s < LOG2N; s++) begin
      k = 0;
      stall_left = (s == 2) ? 3 : 0;
      while (k < 128) begin
        @(negedge clk);
        if (s == stop_s && k == stop_k) return;
        bus.i_start = (s == 3 && k == 10);
        bus.i_stall = (s == 2 && k == 40 && stall_left > 0);
        if (bus.i_stall) stall_left--;
        #1;
        e = model(s, k);
        chk("rd_en", 32'(bus.o_rd_en), 32'(!bus.i_stall));
        chk("rd_addr1", 32'(bus.o_rd_addr1), 32'(e.a1));
        chk("rd_addr2", 32'(bus.o_rd_addr2), 32'(e.a2));
        chk("busy_issue", 32'(bus.o_busy), 32'd1);
        if (!bus.i_stall) begin
          e.cyc = cyc;
          q.push_back(e);
          k++;
        end
      end
      for (int d = 0; d < DRAIN; d++) begin
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_stall = (d % 3 == 1);
        #1;
        chk("drain_rd_en", 32'(bus.o_rd_en), 32'd0);
        chk("drain_busy", 32'(bus.o_busy), 32'd1);
        chk("drain_done", 32'(bus.o_done), 32'd0);
      end
    end
    @(negedge clk);
    bus.i_stall = 1'b0;
    #1;
    chk("done_pulse", 32'(bus.o_done), 32'd1);
    chk("done_busy", 32'(bus.o_busy), 32'd1);
    chk("done_rd_en", 32'(bus.o_rd_en), 32'd0);
    @(negedge clk);
    #1;
    chk("done_clear", 32'(bus.o_done), 32'd0);
    chk("busy_clear", 32'(bus.o_busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(bus.o_rd_en), 32'd0);
    chk({tag, "_rd_addr2"}, 32'(bus.o_rd_addr2), 32'd0);
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
    chk({tag, "_addr1"}, 32'(bus.o_addr1), 32'd0);
    chk({tag, "_stride"}, 32'(bus.o_stride), 32'd0);
    chk({tag, "_tw2"}, 32'(bus.o_twiddle_offset2), 32'd0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.o_done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < LOG2N; s++) vcount[s] = 0;
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_stall = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    run_fft(LOG2N, 0);
    for (int s = 0; s < LOG2N; s++) chk($sformatf("valids_stage%0d", s), 32'(vcount[s]), 32'd128);
    chk("queue_empty_run1", 32'(q.size()), 32'd0);

    run_fft(4, 50);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_reset_busy", 32'(bus.o_busy), 32'd0);
    chk("post_reset_queue", 32'(q.size()), 32'd0);

    run_fft(1, 0);
    chk("queue_empty_run3", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
